// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-level round-robin sharing of one UART TX byte port.
// Build option: define UART_TX_ARB_TIMEOUT_EN to add owner-idle forced release.
//
// Parameters:
//   N_REQ          number of requesters (1..16)
//   GAP_CYCLES     idle cycles forced after a packet's last byte leaves (0 = none)
//   TIMEOUT_CYCLES owner-idle cycles before forced release (timeout build only)
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   req_valid[i]   requester i byte valid
//   req_data       requester i byte in bits [8*i+7:8*i]
//   req_last[i]    requester i final byte of packet
//   req_ready[i]   requester i byte accepted (combinational from tx_ready)
//   tx_valid       byte valid towards the UART TX core
//   tx_data        byte towards the UART TX core
//   tx_ready       UART TX core accepts the byte
//   grant_id       current / last owner index
//   busy           LOCK or GAP, or output register full
//   timeout_o      one-cycle pulse on forced release (timeout build only)
module uart_tx_arbiter #(
   parameter int N_REQ          = 4,
   parameter int GAP_CYCLES     = 0,
   parameter int TIMEOUT_CYCLES = 1024,
   localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [8*N_REQ-1:0] req_data,
   input  logic [N_REQ-1:0]   req_last,
   output logic [N_REQ-1:0]   req_ready,
   output logic               tx_valid,
   output logic [7:0]         tx_data,
   input  logic               tx_ready,
   output logic [IDW-1:0]     grant_id,
   output logic               busy
`ifdef UART_TX_ARB_TIMEOUT_EN
   ,
   output logic               timeout_o
`endif
);

   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOCK,
      S_DRAIN,
      S_GAP
   } state_t;

   state_t         state_q;
   logic [IDW-1:0] grant_q;
   logic [IDW-1:0] ptr_q;
   logic           txv_q;
   logic [7:0]     txd_q;
   logic [GW-1:0]  gap_q;

   logic [IDW-1:0] pick;
   logic           any_req;
   logic           lock;
   logic           out_free;
   logic           own_valid;
   logic           own_last;
   logic [7:0]     own_data;
   logic           own_acc;
   logic           to_fire;
   logic           release_lock;
   logic [IDW-1:0] nxt_owner;

   // Index k positions above base, wrapping at N_REQ.
   function automatic logic [IDW-1:0] rr_idx(
      input logic [IDW-1:0] base,
      input int             k
   );
      int s;
      s = int'(base) + k;
      if (s >= N_REQ) s = s - N_REQ;
      return IDW'(s);
   endfunction

   // Walk from the farthest candidate down to the pointer so the
   // closest requester at or above the pointer wins.
   always_comb begin
      pick    = '0;
      any_req = 1'b0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req_valid[rr_idx(ptr_q, k)]) begin
            pick    = rr_idx(ptr_q, k);
            any_req = 1'b1;
         end
      end
   end

   assign lock      = (state_q == S_LOCK);
   assign out_free  = !txv_q || tx_ready;
   assign own_valid = req_valid[grant_q];
   assign own_last  = req_last[grant_q];
   assign own_data  = req_data[{grant_q, 3'b000} +: 8];
   assign own_acc   = lock && own_valid && out_free;

   always_comb begin
      req_ready = '0;
      if (lock && out_free) req_ready[grant_q] = 1'b1;
   end

   assign nxt_owner = (grant_q == IDW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;

`ifdef UART_TX_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] to_cnt_q;
   logic          to_q;

   // Fires on the TIMEOUT_CYCLES-th consecutive owner-idle cycle.
   assign to_fire = lock && !own_valid &&
                    (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt_q <= '0;
         to_q     <= 1'b0;
      end else begin
         to_q <= to_fire;
         if (lock && !own_valid && !to_fire) begin
            to_cnt_q <= to_cnt_q + 1'b1;
         end else begin
            to_cnt_q <= '0;
         end
      end
   end

   assign timeout_o = to_q;
`else
   assign to_fire = 1'b0;
`endif

   assign release_lock = (own_acc && own_last) || to_fire;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
         txv_q   <= 1'b0;
         txd_q   <= '0;
         gap_q   <= '0;
      end else begin
         // Output register: load and unload may coincide.
         if (own_acc) begin
            txv_q <= 1'b1;
            txd_q <= own_data;
         end else if (tx_ready) begin
            txv_q <= 1'b0;
         end

         unique case (state_q)
            S_IDLE: begin
               if (any_req) begin
                  grant_q <= pick;
                  state_q <= S_LOCK;
               end
            end
            S_LOCK: begin
               if (release_lock) begin
                  ptr_q   <= nxt_owner;
                  state_q <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (out_free) begin
                  if (GAP_CYCLES > 0) begin
                     gap_q   <= GW'(GAP_CYCLES - 1);
                     state_q <= S_GAP;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end
            end
            S_GAP: begin
               if (gap_q == '0) begin
                  state_q <= S_IDLE;
               end else begin
                  gap_q <= gap_q - 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign tx_valid = txv_q;
   assign tx_data  = txd_q;
   assign grant_id = grant_q;
   assign busy     = lock || (state_q == S_GAP) || txv_q;

endmodule
